// File: rtl/arbitro_memoria_if.sv
// Bundle of the fetch, load/store and memory-side signals around the memory arbiter.
// slave = the arbiter itself; master = everything around it (requesters and memory).
interface arbitro_memoria_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch and load/store requesters; one access in flight at a time.
module arbitro_memoria #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  arbitro_memoria_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              win_d_q, win_d_d;     // 1: current access belongs to D
  logic              last_d_q, last_d_d;   // 1: D won the most recent grant
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pick_d;
  logic              issue;
  logic              read_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_d_q  <= win_d_d;
      last_d_q <= last_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state and latch logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d_d  = win_d_q;
    last_d_d = last_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pick_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie the requester that did not win last time goes first.
          pick_d   = bus.d_req && (!bus.i_req || !last_d_q);
          win_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = pick_d && bus.d_we;
          addr_d   = pick_d ? bus.d_addr : bus.i_addr;
          wdata_d  = pick_d ? bus.d_wdata : '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_C) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pure decodes of registered state, apart from the read-data pass-through
  always_comb begin
    issue     = (state_q == ISSUE);
    read_done = (state_q == WAIT) && (cnt_q == LAT_C);

    bus.mem_en    = issue;
    bus.mem_we    = issue && we_q;
    bus.mem_addr  = issue ? addr_q : '0;
    bus.mem_wdata = (issue && we_q) ? wdata_q : '0;

    bus.i_ack    = issue && !win_d_q;
    bus.d_ack    = issue && win_d_q;
    bus.i_rvalid = read_done && !win_d_q;
    bus.d_rvalid = read_done && win_d_q;
    bus.i_rdata  = (read_done && !win_d_q) ? bus.mem_rdata : '0;
    bus.d_rdata  = (read_done && win_d_q) ? bus.mem_rdata : '0;

    bus.busy = (state_q != IDLE);
  end

endmodule
